// File: rtl/lsu_bus_if.sv
// Data-bus bundle between the load/store unit and memory.
// Request/grant/response with a single outstanding access.
interface lsu_bus_if #(
   parameter int ADDR_W = 32
) ();
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: stalls the core while one data-bus
// access runs, steers lanes, extends load data, flags faults/timeouts.
module lsu_bus_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              LoadOp,
   input  logic              StoreOp,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              load_done,
   output logic              access_fault,
   output logic              bus_timeout,
   lsu_bus_if.master         bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q;
   logic [1:0]        off_q;
   logic [1:0]        wid_q;
   logic              sgn_q;
   logic [31:0]       rdata_q;
   logic              done_q;
   logic              to_q;

   logic        op;
   logic        st;
   logic        bad;
   logic [3:0]  be_n;
   logic [31:0] wd_n;

   assign op = LoadOp | StoreOp;
   assign st = StoreOp & ~LoadOp;

   assign bad = (funct3 == 3'b011)
              | (funct3[2:1] == 2'b11)
              | (st & funct3[2])
              | ((funct3[1:0] == 2'b01) & addr[0])
              | ((funct3[1:0] == 2'b10) & (|addr[1:0]));

   always_comb begin
      be_n = 4'b0000;
      wd_n = 32'd0;
      unique case (1'b1)
         (funct3[1:0] == 2'b00): begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
         end
         (funct3[1:0] == 2'b01): begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{wdata[15:0]}};
         end
         (funct3[1:0] == 2'b10): begin
            be_n = 4'b1111;
            wd_n = wdata;
         end
         default: ;
      endcase
   end

   function automatic logic [31:0] ext(
      input logic [31:0] d,
      input logic [1:0]  off,
      input logic [1:0]  wid,
      input logic        sgn
   );
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      unique case (wid)
         2'b00:   ext = {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   ext = {{16{sgn & sh[15]}}, sh[15:0]};
         default: ext = d;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wd_q    <= 32'd0;
         off_q   <= 2'b00;
         wid_q   <= 2'b00;
         sgn_q   <= 1'b0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         to_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (op & ~bad) begin
                  we_q   <= st;
                  addr_q <= {addr[ADDR_W-1:2], 2'b00};
                  be_q   <= be_n;
                  wd_q   <= wd_n;
                  off_q  <= addr[1:0];
                  wid_q  <= funct3[1:0];
                  sgn_q  <= ~funct3[2];
                  cnt    <= '0;
                  req_q  <= 1'b1;
                  state  <= REQ;
               end
            end
            REQ: begin
               // a load may be granted and answered in the same cycle
               if (bus.bus_gnt & ~we_q & bus.bus_rvalid) begin
                  rdata_q <= ext(bus.bus_rdata, off_q, wid_q, sgn_q);
                  done_q  <= 1'b1;
                  req_q   <= 1'b0;
                  state   <= DONE;
               end else if (bus.bus_gnt & we_q) begin
                  req_q <= 1'b0;
                  state <= DONE;
               end else if (cnt == CMAX) begin
                  req_q   <= 1'b0;
                  to_q    <= 1'b1;
                  rdata_q <= 32'd0;
                  state   <= DONE;
               end else if (bus.bus_gnt) begin
                  req_q <= 1'b0;
                  cnt   <= cnt + 1'b1;
                  state <= WAIT_R;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_R: begin
               if (bus.bus_rvalid) begin
                  rdata_q <= ext(bus.bus_rdata, off_q, wid_q, sgn_q);
                  done_q  <= ~we_q;
                  state   <= DONE;
               end else if (cnt == CMAX) begin
                  to_q    <= 1'b1;
                  rdata_q <= 32'd0;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   assign stall = ~reset & (((state == IDLE) & op & ~bad)
                | (state == REQ) | (state == WAIT_R));
   assign access_fault = ~reset & (state == IDLE) & op & bad;
   assign rdata = ((state == IDLE) & LoadOp & bad) ? 32'd0 : rdata_q;
   assign load_done   = done_q;
   assign bus_timeout = to_q;

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wd_q;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed vector table, reset-in-flight
// sequence and random accesses against a behavioural model.
module tb_lsu_bus_ctrl;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        LoadOp, StoreOp;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, load_done, access_fault, bus_timeout;
   logic [31:0] rdata;

   lsu_bus_if #(.ADDR_W(32)) bus ();

   lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .LoadOp(LoadOp), .StoreOp(StoreOp),
      .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata),
      .load_done(load_done), .access_fault(access_fault),
      .bus_timeout(bus_timeout), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdv;
      int          gd;
      int          rdd;
      logic        fault;
      logic        we;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] rd;
      int          stl;
      int          req;
      int          done;
      int          to;
   } vec_t;

   int checks = 0;
   int failures = 0;

   int          o_stall, o_done, o_fault, o_to, o_req, o_hang, o_unst;
   logic [3:0]  o_be;
   logic [31:0] o_wd, o_addr, o_rd;
   logic        o_we;

   vec_t tbl[15];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   function automatic vec_t model(input vec_t v);
      vec_t e;
      int sz, off, fin;
      logic isl, iss, tmo;
      longint val;
      e = v;
      isl = v.ld;
      iss = v.st & ~v.ld;
      off = int'(v.a % 4);
      sz = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      e.fault = (v.f3 == 3) || (v.f3 == 6) || (v.f3 == 7)
              || (iss && (v.f3 == 4 || v.f3 == 5))
              || ((v.a % sz) != 0);
      e.we = iss;
      e.be = 4'(((1 << sz) - 1) << off);
      e.bwd = (sz == 1) ? v.wd[7:0] * 32'h01010101 :
              (sz == 2) ? v.wd[15:0] * 32'h00010001 : v.wd;
      val = longint'(v.rdv) >> (8 * off);
      if (sz < 4) begin
         val = val % (longint'(1) << (8 * sz));
         if (!v.f3[2] && val >= (longint'(1) << (8 * sz - 1)))
            val = val - (longint'(1) << (8 * sz));
      end
      fin = isl ? v.gd + v.rdd : v.gd;
      tmo = fin > TO - 1;
      if (e.fault) begin
         e.stl = 0; e.req = 0; e.done = 0; e.to = 0; e.rd = 0;
      end else begin
         e.stl = 1 + (tmo ? TO : fin + 1);
         e.req = (v.gd <= TO - 1) ? v.gd + 1 : TO;
         e.done = (isl && !tmo) ? 1 : 0;
         e.to = tmo ? 1 : 0;
         e.rd = tmo ? 32'd0 : val[31:0];
      end
      return e;
   endfunction

   task automatic sample_extra();
      if (stall) o_stall++;
      if (bus.bus_req) o_req++;
      o_done += int'(load_done);
      o_fault += int'(access_fault);
      o_to += int'(bus_timeout);
   endtask

   task automatic run_op(input vec_t v);
      int k0, gk, cyc;
      bit gg, ended;
      o_stall = 0; o_done = 0; o_fault = 0; o_to = 0; o_req = 0;
      o_hang = 0; o_unst = 0; o_be = 0; o_wd = 0; o_addr = 0;
      o_we = 0; o_rd = 0;
      k0 = -1; gk = 0; gg = 0; ended = 0;
      @(posedge clk); #1;
      LoadOp = v.ld; StoreOp = v.st; funct3 = v.f3;
      addr = v.a; wdata = v.wd;
      for (cyc = 0; cyc < 300 && !ended; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
         end
         if (bus.bus_req && k0 < 0) k0 = cyc;
         bus.bus_gnt = bus.bus_req && k0 >= 0 && (cyc - k0) == v.gd;
         if (bus.bus_gnt) begin gg = 1; gk = cyc - k0; end
         bus.bus_rvalid = v.ld && gg && (cyc - k0) == gk + v.rdd;
         bus.bus_rdata = bus.bus_rvalid ? v.rdv : $urandom;
         #4;
         if (bus.bus_req) begin
            o_req++;
            if (o_req == 1) begin
               o_be = bus.bus_be; o_wd = bus.bus_wdata;
               o_addr = bus.bus_addr; o_we = bus.bus_we;
            end else if (o_be != bus.bus_be || o_wd != bus.bus_wdata ||
                         o_addr != bus.bus_addr || o_we != bus.bus_we)
               o_unst = 1;
         end
         if (stall) o_stall++;
         o_done += int'(load_done);
         o_fault += int'(access_fault);
         o_to += int'(bus_timeout);
         if (!stall) begin ended = 1; o_rd = rdata; end
      end
      if (!ended) o_hang = 1;
      // stray read response after the access has ended must be ignored
      @(posedge clk); #1;
      LoadOp = 0; StoreOp = 0;
      bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = $urandom;
      #4; sample_extra();
      repeat (2) begin
         @(posedge clk); #1; bus.bus_rvalid = 0; #4; sample_extra();
      end
   endtask

   task automatic check_vec(input vec_t e, input string t);
      chk({t, "_hang"}, o_hang, 0);
      chk({t, "_fault"}, o_fault, e.fault ? 1 : 0);
      chk({t, "_stall"}, o_stall, e.stl);
      chk({t, "_req"}, o_req, e.req);
      chk({t, "_done"}, o_done, e.done);
      chk({t, "_tmo"}, o_to, e.to);
      if (!e.fault) begin
         chk({t, "_be"}, {28'd0, o_be}, {28'd0, e.be});
         chk({t, "_addr"}, o_addr, e.a & 32'hFFFF_FFFC);
         chk({t, "_we"}, {31'd0, o_we}, {31'd0, e.we});
         chk({t, "_stable"}, o_unst, 0);
         if (e.we) chk({t, "_wdata"}, o_wd, e.bwd);
      end
      if (e.ld) chk({t, "_rdata"}, o_rd, e.rd);
   endtask

   initial begin
      vec_t v, e;
      reset = 1; LoadOp = 0; StoreOp = 0; funct3 = 0;
      addr = 0; wdata = 0;
      bus.bus_gnt = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0;

      // ld st f3 a wd rdv gd rdd | fault we be bwd rd stl req done to
      tbl[0]  = '{0,1,2,32'h104,32'hDEADBEEF,0,0,0,
                  0,1,4'hF,32'hDEADBEEF,0,2,1,0,0};
      tbl[1]  = '{1,0,0,32'h203,0,32'h80FF1234,0,2,
                  0,0,4'h8,0,32'hFFFFFF80,4,1,1,0};
      tbl[2]  = '{1,0,4,32'h203,0,32'h80FF1234,0,2,
                  0,0,4'h8,0,32'h00000080,4,1,1,0};
      tbl[3]  = '{0,1,1,32'h302,32'h0000ABCD,0,0,0,
                  0,1,4'hC,32'hABCDABCD,0,2,1,0,0};
      tbl[4]  = '{1,0,5,32'h302,0,32'hBEEF0000,0,1,
                  0,0,4'hC,0,32'h0000BEEF,3,1,1,0};
      tbl[5]  = '{1,0,2,32'h101,0,0,0,1,
                  1,0,0,0,0,0,0,0,0};
      tbl[6]  = '{1,0,3,32'h100,0,0,0,1,
                  1,0,0,0,0,0,0,0,0};
      tbl[7]  = '{1,0,2,32'h0,0,32'h12345678,1,0,
                  0,0,4'hF,0,32'h12345678,3,2,1,0};
      tbl[8]  = '{0,1,0,32'h101,32'h0000005A,0,3,0,
                  0,1,4'h2,32'h5A5A5A5A,0,5,4,0,0};
      tbl[9]  = '{1,0,1,32'h102,0,32'h80010000,0,1,
                  0,0,4'hC,0,32'hFFFF8001,3,1,1,0};
      tbl[10] = '{0,1,4,32'h100,32'h1,0,0,0,
                  1,0,0,0,0,0,0,0,0};
      tbl[11] = '{1,1,2,32'h8,0,32'hCAFEF00D,0,1,
                  0,0,4'hF,0,32'hCAFEF00D,3,1,1,0};
      tbl[12] = '{1,0,2,32'h40,0,32'h5555AAAA,100,0,
                  0,0,4'hF,0,0,TO+1,TO,0,1};
      tbl[13] = '{1,1,2,32'h44,0,32'h5555AAAA,0,100,
                  0,0,4'hF,0,0,TO+1,1,0,1};
      tbl[14] = '{0,1,2,32'h48,32'h11223344,0,100,0,
                  0,1,4'hF,32'h11223344,0,TO+1,TO,0,1};

      repeat (3) @(posedge clk);
      #1 reset = 0;
      #4;
      chk("rst_stall", stall, 0);
      chk("rst_req", bus.bus_req, 0);
      chk("rst_we", bus.bus_we, 0);
      chk("rst_be", bus.bus_be, 0);
      chk("rst_addr", bus.bus_addr, 0);
      chk("rst_wdata", bus.bus_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_done", load_done, 0);
      chk("rst_fault", access_fault, 0);
      chk("rst_tmo", bus_timeout, 0);

      for (int i = 0; i < 15; i++) begin
         run_op(tbl[i]);
         check_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // reset while waiting for read data
      @(posedge clk); #1;
      LoadOp = 1; StoreOp = 0; funct3 = 3'd2; addr = 32'h10;
      @(posedge clk); #1;
      bus.bus_gnt = bus.bus_req;
      @(posedge clk); #1;
      bus.bus_gnt = 0;
      #4 chk("mid_wait_stall", stall, 1);
      chk("mid_wait_req", bus.bus_req, 0);
      @(posedge clk); #1;
      reset = 1; LoadOp = 0;
      @(posedge clk); #1;
      reset = 0;
      #4;
      chk("mrst_stall", stall, 0);
      chk("mrst_req", bus.bus_req, 0);
      chk("mrst_be", bus.bus_be, 0);
      chk("mrst_addr", bus.bus_addr, 0);
      chk("mrst_rdata", rdata, 0);
      chk("mrst_done", load_done, 0);
      chk("mrst_tmo", bus_timeout, 0);
      v = '{1,0,2,32'h0,0,32'h0BADF00D,0,1,
            0,0,0,0,0,0,0,0,0};
      e = model(v);
      run_op(v);
      check_vec(e, "after_rst");

      for (int i = 0; i < 40; i++) begin
         v.ld = 1'($urandom_range(0, 1));
         v.st = v.ld ? 1'($urandom_range(0, 1)) : 1'b1;
         v.f3 = 3'($urandom_range(0, 7));
         v.a = $urandom;
         if ($urandom_range(0, 1) == 0) v.a[1:0] = 2'b00;
         v.wd = $urandom;
         v.rdv = $urandom;
         v.gd = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 3);
         v.rdd = $urandom_range(0, 3);
         e = model(v);
         run_op(v);
         check_vec(e, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit that consumes the main decoder's memory controls (LoadOp, StoreOp) and funct3.
- Turns them into a request/grant/response transaction on the data bus.
- Stalls the single-cycle core until the access completes.
- Handles byte/half/word lane steering, read-data sign/zero extension, misalignment detection and bus timeout.

Parameters:
- ADDR_W, 32, byte address width
- TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT_R before the access is aborted with bus_timeout

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- LoadOp  in  1  load instruction in execute (from maindecoder)
- StoreOp  in  1  store instruction in execute (from maindecoder)
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  holds PC and regfile write enable while an access is pending
- rdata  out  32  extended load result, valid when load_done=1
- load_done  out  1  one-cycle pulse: rdata valid, regfile may write
- access_fault  out  1  one-cycle pulse: misaligned address or illegal funct3, no bus access made
- bus_timeout  out  1  one-cycle pulse: bus did not respond within TIMEOUT_CYCLES
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid this cycle
- bus_rdata  in  32  read data

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0: stall, rdata, load_done, access_fault, bus_timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata.
- op = LoadOp|StoreOp; if both are 1, treat as load.
- Fault check:
  - bad = funct3 in {011,110,111}
  - or store funct3 in {100,101}
  - or H/HU with addr[0]=1
  - or W with addr[1:0]!=00
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - op & bad: access_fault=1 combinationally, stall=0, no bus activity; loads present rdata=0 with load_done=0.
  - op & !bad: stall=1. Next edge captures we, bus_addr, bus_be, bus_wdata, width and sign into registers, goes to REQ.
  - no op: stall=0.
- REQ: bus_req=1; address/we/be/wdata held stable until bus_gnt.
  - gnt & store: go DONE.
  - gnt & load: go WAIT_R.
  - A same-cycle bus_rvalid with gnt is accepted: capture data, go DONE.
- WAIT_R: bus_req=0; on bus_rvalid, capture the extended data, go DONE.
- DONE: stall=0. Loads pulse load_done=1 with rdata valid. Go IDLE next edge. A new op seen in IDLE starts a fresh access.
- Total latency with gnt and rvalid each after 1 cycle:
  - store: stall for 2 cycles;
  - load: stall for 3 cycles, load_done in the 4th.
- Stall covers IDLE with op & !bad, REQ and WAIT_R.
- Lane steering:
  - B: be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - W: be = 1111, wdata unchanged.
  - bus_we=0 on loads; be still reflects width.
- Load extract: sh = bus_rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0]; BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]; HU: zero-extend sh[15:0].
  - W: bus_rdata unchanged.
  - rdata registered at capture, held until the next capture or reset.
- Timeout: counter clears on entering REQ and counts each cycle in REQ and WAIT_R.
  - On reaching TIMEOUT_CYCLES-1 without completion: drop bus_req, pulse bus_timeout in DONE, rdata=0, load_done=0, go IDLE.
  - A late bus_rvalid arriving in IDLE is ignored.
- Reset mid-access, any state: IDLE at that edge, bus_req low from the next cycle, no pulses.
- Inputs addr/wdata/funct3 may change while stalled; only the captured values are used.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, gnt 1 cycle after req:
  - bus_we=1, be=1111, bus_addr=0x104, bus_wdata=0xDEADBEEF;
  - stall high 2 cycles; no load_done.
- LB addr=0x203, bus_rdata=0x80FF1234, rvalid 2 cycles after gnt:
  - be=1000; rdata=0xFFFFFF80; load_done pulses exactly once.
  - Repeat as LBU: rdata=0x00000080.
- SH addr=0x302, wdata=0x0000ABCD: be=1100, bus_wdata=0xABCDABCD. LHU addr=0x302, bus_rdata=0xBEEF0000: rdata=0x0000BEEF.
- LW addr=0x101 (misaligned) and funct3=011:
  - access_fault pulses, stall=0, bus_req never asserts, state stays IDLE.
- LW with bus_gnt held low for TIMEOUT_CYCLES:
  - bus_timeout pulses once, bus_req drops, rdata=0, stall releases.
  - A later stray bus_rvalid causes no load_done.
- Assert reset while in WAIT_R:
  - all outputs 0 next cycle, state IDLE;
  - a following LW to 0x0 completes normally with gnt and rvalid.
